// File: rtl/psg_pkg.sv
// Shared types and constants for the PSG bus front end and register file.
package psg_pkg;

    typedef enum logic [2:0] {
        TONE0  = 3'd0,
        ATTEN0 = 3'd1,
        TONE1  = 3'd2,
        ATTEN1 = 3'd3,
        TONE2  = 3'd4,
        ATTEN2 = 3'd5,
        NOISE  = 3'd6,
        ATTEN3 = 3'd7
    } psg_reg_e;

    localparam logic [3:0] ATTEN_SILENT   = 4'hF;
    localparam logic [9:0] TONE_RST       = 10'd0;
    localparam logic [7:0] PSG_PORT_MASK  = 8'hC0;
    localparam logic [7:0] PSG_PORT_MATCH = 8'h40;

    // Latch bytes carry the low nibble of a period, data bytes the upper six bits.
    function automatic logic [9:0] tone_upd(input logic [9:0] old, input logic [7:0] d);
        return d[7] ? {old[9:4], d[3:0]} : {d[5:0], old[3:0]};
    endfunction

endpackage

// File: rtl/psg_wr_sync.sv
// Synchronizes an async active-low write strobe and emits one fire pulse per
// inactive->active transition.
module psg_wr_sync (
    input  logic clk,
    input  logic rst_l,
    input  logic strobe_l,
    output logic fire
);

    logic [2:0] sync;
    logic [2:0] vld_pipe;

    // vld_pipe[k] marks sync[k] as holding a genuine post-reset sample, so a
    // strobe held through reset release never looks like a fresh assertion.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sync     <= '1;
            vld_pipe <= '0;
            fire     <= 1'b0;
        end else begin
            sync     <= {sync[1:0], strobe_l};
            vld_pipe <= {vld_pipe[1:0], 1'b1};
            fire     <= vld_pipe[2] & sync[2] & ~sync[1];
        end
    end

endmodule

// File: rtl/psg_bus_if.sv
// Z80 I/O write snooper that decodes SN76489 latch/data bytes into the PSG
// tone, attenuation and noise registers.
module psg_bus_if
    import psg_pkg::*;
#(
    parameter logic [7:0] PORT_MASK  = PSG_PORT_MASK,
    parameter logic [7:0] PORT_MATCH = PSG_PORT_MATCH
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic [7:0]  data_bus,
    input  logic [15:0] addr_bus,
    input  logic        iorq_l,
    input  logic        wr_l,
    output logic [9:0]  tone0_per,
    output logic [9:0]  tone1_per,
    output logic [9:0]  tone2_per,
    output logic [3:0]  atten0,
    output logic [3:0]  atten1,
    output logic [3:0]  atten2,
    output logic [3:0]  atten3,
    output logic [2:0]  noise_ctrl,
    output logic        noise_rst,
    output logic        wr_ack
);

    logic     wr_act;
    logic     fire;
    logic     wr_en;
    psg_reg_e cur_reg;
    psg_reg_e tgt;

    assign wr_act = ~iorq_l & ~wr_l;

    psg_wr_sync u_sync (
        .clk      (clk),
        .rst_l    (rst_l),
        .strobe_l (~wr_act),
        .fire     (fire)
    );

    // Bus holds address and data for the whole I/O cycle, so sample directly.
    assign wr_en = fire && ((addr_bus[7:0] & PORT_MASK) == PORT_MATCH);

    always_comb begin
        tgt = cur_reg;
        if (data_bus[7])
            tgt = psg_reg_e'(data_bus[6:4]);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            tone0_per  <= TONE_RST;
            tone1_per  <= TONE_RST;
            tone2_per  <= TONE_RST;
            atten0     <= ATTEN_SILENT;
            atten1     <= ATTEN_SILENT;
            atten2     <= ATTEN_SILENT;
            atten3     <= ATTEN_SILENT;
            noise_ctrl <= 3'd0;
            noise_rst  <= 1'b0;
            wr_ack     <= 1'b0;
            cur_reg    <= TONE0;
        end else begin
            wr_ack    <= 1'b0;
            noise_rst <= 1'b0;
            if (wr_en) begin
                wr_ack <= 1'b1;
                if (data_bus[7])
                    cur_reg <= tgt;
                case (tgt)
                    TONE0:  tone0_per <= tone_upd(tone0_per, data_bus);
                    TONE1:  tone1_per <= tone_upd(tone1_per, data_bus);
                    TONE2:  tone2_per <= tone_upd(tone2_per, data_bus);
                    ATTEN0: atten0    <= data_bus[3:0];
                    ATTEN1: atten1    <= data_bus[3:0];
                    ATTEN2: atten2    <= data_bus[3:0];
                    ATTEN3: atten3    <= data_bus[3:0];
                    NOISE: begin
                        noise_ctrl <= data_bus[2:0];
                        noise_rst  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psg_bus_if.sv
// Directed vector bench for psg_bus_if: table of bus writes with expected
// register state, plus hand sequences for reset-during-strobe.
module tb_psg_bus_if;

    logic        clk;
    logic        rst_l;
    logic [7:0]  data_bus;
    logic [15:0] addr_bus;
    logic        iorq_l;
    logic        wr_l;
    logic [9:0]  tone0_per, tone1_per, tone2_per;
    logic [3:0]  atten0, atten1, atten2, atten3;
    logic [2:0]  noise_ctrl;
    logic        noise_rst;
    logic        wr_ack;

    int checks   = 0;
    int failures = 0;

    psg_bus_if dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .data_bus   (data_bus),
        .addr_bus   (addr_bus),
        .iorq_l     (iorq_l),
        .wr_l       (wr_l),
        .tone0_per  (tone0_per),
        .tone1_per  (tone1_per),
        .tone2_per  (tone2_per),
        .atten0     (atten0),
        .atten1     (atten1),
        .atten2     (atten2),
        .atten3     (atten3),
        .noise_ctrl (noise_ctrl),
        .noise_rst  (noise_rst),
        .wr_ack     (wr_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          hold;
        int          acks;
        int          nrsts;
        logic [9:0]  t0;
        logic [9:0]  t1;
        logic [9:0]  t2;
        logic [15:0] att;   // {atten3, atten2, atten1, atten0}
        logic [2:0]  nc;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one I/O write holding the strobe for 'hold' cycles, then idle long
    // enough for the deassert to propagate; count pulses and first-ack edge.
    task automatic do_write(input logic [15:0] addr, input logic [7:0] data, input int hold,
                            output int acks, output int nrsts, output int lat);
        @(negedge clk);
        addr_bus = addr;
        data_bus = data;
        iorq_l   = 1'b0;
        wr_l     = 1'b0;
        acks  = 0;
        nrsts = 0;
        lat   = -1;
        for (int k = 1; k <= hold + 6; k++) begin
            @(posedge clk);
            #1;
            if (wr_ack) begin
                acks++;
                if (lat < 0) lat = k;
            end
            if (noise_rst) nrsts++;
            if (k == hold) begin
                iorq_l = 1'b1;
                wr_l   = 1'b1;
            end
        end
    endtask

    task automatic check_regs(input string tag, input vec_t v);
        check({tag, ".tone0"}, 32'(tone0_per), 32'(v.t0));
        check({tag, ".tone1"}, 32'(tone1_per), 32'(v.t1));
        check({tag, ".tone2"}, 32'(tone2_per), 32'(v.t2));
        check({tag, ".atten"}, 32'({atten3, atten2, atten1, atten0}), 32'(v.att));
        check({tag, ".noise_ctrl"}, 32'(noise_ctrl), 32'(v.nc));
    endtask

    initial begin
        int   acks, nrsts, lat;
        vec_t rv;

        vecs[0]  = '{16'h007F, 8'h8E,  4, 1, 0, 10'h00E, 10'h000, 10'h000, 16'hFFFF, 3'd0};
        vecs[1]  = '{16'hAB7F, 8'h0F,  3, 1, 0, 10'h0FE, 10'h000, 10'h000, 16'hFFFF, 3'd0};
        vecs[2]  = '{16'h007F, 8'hD5,  4, 1, 0, 10'h0FE, 10'h000, 10'h000, 16'hF5FF, 3'd0};
        vecs[3]  = '{16'h007F, 8'h0A,  4, 1, 0, 10'h0FE, 10'h000, 10'h000, 16'hFAFF, 3'd0};
        vecs[4]  = '{16'h007F, 8'hE6,  4, 1, 1, 10'h0FE, 10'h000, 10'h000, 16'hFAFF, 3'd6};
        vecs[5]  = '{16'h007F, 8'h01,  4, 1, 1, 10'h0FE, 10'h000, 10'h000, 16'hFAFF, 3'd1};
        vecs[6]  = '{16'h00BE, 8'h9F,  4, 0, 0, 10'h0FE, 10'h000, 10'h000, 16'hFAFF, 3'd1};
        vecs[7]  = '{16'h0040, 8'h90, 20, 1, 0, 10'h0FE, 10'h000, 10'h000, 16'hFAF0, 3'd1};
        vecs[8]  = '{16'h003F, 8'h9F,  4, 0, 0, 10'h0FE, 10'h000, 10'h000, 16'hFAF0, 3'd1};
        vecs[9]  = '{16'h007F, 8'hC5,  4, 1, 0, 10'h0FE, 10'h000, 10'h005, 16'hFAF0, 3'd1};
        vecs[10] = '{16'h007F, 8'h7A,  4, 1, 0, 10'h0FE, 10'h000, 10'h3A5, 16'hFAF0, 3'd1};
        vecs[11] = '{16'h0080, 8'hEF,  4, 0, 0, 10'h0FE, 10'h000, 10'h3A5, 16'hFAF0, 3'd1};
        vecs[12] = '{16'h007F, 8'hEF,  4, 1, 1, 10'h0FE, 10'h000, 10'h3A5, 16'hFAF0, 3'd7};

        rst_l    = 1'b0;
        iorq_l   = 1'b1;
        wr_l     = 1'b1;
        addr_bus = '0;
        data_bus = '0;
        repeat (3) @(posedge clk);
        #1;
        rv = '{16'h0, 8'h0, 0, 0, 0, 10'h000, 10'h000, 10'h000, 16'hFFFF, 3'd0};
        check_regs("reset", rv);
        check("reset.wr_ack", 32'(wr_ack), 32'd0);
        check("reset.noise_rst", 32'(noise_rst), 32'd0);
        @(negedge clk);
        rst_l = 1'b1;
        repeat (4) @(posedge clk);

        for (int i = 0; i < 13; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            do_write(vecs[i].addr, vecs[i].data, vecs[i].hold, acks, nrsts, lat);
            check({tag, ".acks"}, 32'(acks), 32'(vecs[i].acks));
            check({tag, ".noise_rst"}, 32'(nrsts), 32'(vecs[i].nrsts));
            if (vecs[i].acks > 0)
                check({tag, ".latency"}, 32'(lat), 32'd4);
            check_regs(tag, vecs[i]);
        end

        // Reset arrives while a latch to tone1 is mid-strobe and releases
        // with the strobe still low: nothing may fire.
        @(negedge clk);
        addr_bus = 16'h007F;
        data_bus = 8'hA3;
        iorq_l   = 1'b0;
        wr_l     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_l = 1'b0;
        #1;
        rv = '{16'h0, 8'h0, 0, 0, 0, 10'h000, 10'h000, 10'h000, 16'hFFFF, 3'd0};
        check_regs("midrst", rv);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_l = 1'b1;
        acks = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (wr_ack) acks++;
        end
        check("midrst.acks", 32'(acks), 32'd0);
        check("midrst.tone1", 32'(tone1_per), 32'd0);
        @(negedge clk);
        iorq_l = 1'b1;
        wr_l   = 1'b1;
        repeat (5) @(posedge clk);

        // Data byte with no latch since reset lands in tone0's upper bits.
        do_write(16'h007F, 8'h3F, 4, acks, nrsts, lat);
        check("postrst.acks", 32'(acks), 32'd1);
        check("postrst.tone0", 32'(tone0_per), 32'h3F0);
        check("postrst.tone1", 32'(tone1_per), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psg_bus_if.md
Name: psg_bus_if

Overview:
- Upstream front end of the PSG. Watches Z80 I/O write cycles on the shared bus and filters those addressed to the PSG.
- Decodes the SN76489 latch/data byte protocol into the PSG register file: three 10-bit tone periods, four 4-bit attenuations and a 3-bit noise control.
- Register outputs feed the PSG tone/noise generators directly. The block never drives the bus.

Parameters:
- PORT_MASK, 8'hC0, mask applied to addr_bus[7:0] for port decode.
- PORT_MATCH, 8'h40, value that masked addr_bus[7:0] must equal to select the PSG (SMS ports 0x40–0x7F).

Ports:
- clk  input  1  system clock
- rst_l  input  1  asynchronous active-low reset
- data_bus  input  8  Z80 data bus (observed only, never driven)
- addr_bus  input  16  Z80 address bus; only [7:0] decoded
- iorq_l  input  1  Z80 IORQ, active low, asynchronous to clk
- wr_l  input  1  Z80 WR, active low, asynchronous to clk
- tone0_per, tone1_per, tone2_per  output  10 each  tone period registers
- atten0, atten1, atten2, atten3  output  4 each  attenuation; atten3 is noise
- noise_ctrl  output  3  [2]=white/periodic, [1:0]=shift rate
- noise_rst  output  1  one-cycle pulse; restarts the noise LFSR
- wr_ack  output  1  one-cycle pulse per accepted PSG write (debug/verification)

Behaviour:
- Reset (async, rst_l=0) values:
  - tone*_per = 0.
  - atten* = 4'hF (silent).
  - noise_ctrl = 0.
  - Latched register index = tone0 (3'd0).
  - noise_rst = 0, wr_ack = 0.
  - Synchronizer flops = 1 (strobe inactive).
- Strobe: wr_act = ~iorq_l & ~wr_l.
  - Passed through a 2-flop synchronizer, then a falling-edge detect (inactive→active) yields one "fire" cycle per write.
  - A strobe held low for many cycles fires exactly once.
  - A strobe must be active ≥3 clk cycles to be guaranteed seen.
- Capture: on the fire cycle, data_bus and addr_bus[7:0] are sampled directly. The Z80 holds both for the whole I/O cycle, so no extra synchronization.
  - If (addr[7:0] & PORT_MASK) != PORT_MATCH, the write is ignored. No state change, no wr_ack.
- Latch byte (d[7]=1):
  - idx = {d[6:5], d[4]}. d[4]=1 selects attenuation, d[4]=0 selects tone/noise.
  - The latched index register is updated to idx.
  - Tone idx: period[3:0] = d[3:0]; period[9:4] unchanged.
  - Atten idx: atten = d[3:0].
  - Noise idx (ch3, type 0): noise_ctrl = d[2:0], d[3] ignored; noise_rst pulses.
- Data byte (d[7]=0): applies to the current latched index.
  - Tone: period[9:4] = d[5:0]; period[3:0] unchanged.
  - Atten: atten = d[3:0].
  - Noise: noise_ctrl = d[2:0]; noise_rst pulses.
  - d[6] is ignored.
- Latency: register outputs, wr_ack and noise_rst all update on the clock edge ending the fire cycle. That is 3 clk after strobe assertion is first sampled.
- Register writes are single-cycle. No back-pressure; writes can never be dropped if the strobe timing is met.
- Consecutive writes need the strobe to return inactive for ≥3 cycles between them. Re-fire occurs only after the deassert is seen.
- Reset mid-cycle: every register clears immediately. A strobe still active when reset releases does not fire, because the edge detect needs an inactive→active transition after reset.
- A data byte after reset with no prior latch byte applies to tone0.

Decomposition:
- psg_pkg holds:
  - psg_reg_e enum (TONE0, ATTEN0, TONE1, ATTEN1, TONE2, ATTEN2, NOISE, ATTEN3 = 3'd0..3'd7).
  - Reset constants ATTEN_SILENT = 4'hF and TONE_RST = 10'd0.
  - Default port mask/match constants.
- One sub-module, psg_wr_sync: 2-flop synchronizer plus falling-edge detect, output fire. It is reused later for the VDP port interface.

Test Plan:
- Reset: assert rst_l=0 → all tone*_per=0, all atten*=F, noise_ctrl=0, noise_rst=0.
- Tone write: OUT 0x7F with 0x8E, then 0x0F → tone0_per=10'h0FE; wr_ack pulses twice; 1 clk each.
- Attenuation and data reuse: OUT 0x7F with 0xD5 → atten2=5. Then data byte 0x0A → atten2=A, index retained.
- Noise: OUT 0x7F with 0xE6 → noise_ctrl=3'b110; noise_rst high exactly 1 cycle. Then data byte 0x01 → noise_ctrl=1, second noise_rst pulse.
- Port decode and long strobe:
  - OUT 0xBE with 0x9F → no change, no wr_ack.
  - OUT 0x40 with 0x90 while holding the strobe low 20 cycles → atten0=0, exactly one wr_ack.
- Reset mid-sequence: latch 0xA3 (tone1 low=3), assert rst_l mid-strobe, release while strobe still low → tone1_per stays 0. A following data byte 0x3F writes tone0_per=10'h3F0.
